mem_page_responder: RTL and testbench

//  Memory-side responder on the main bus: answers the read/write bursts that processor-side

---
 rtl/mem_page_responder_pkg.sv | 21 ++
 rtl/mem_page_array.sv | 19 +
 rtl/mem_page_responder.sv | 114 +++++++++++
 tb/tb_mem_page_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_page_responder_pkg.sv
// Shared types for the main-bus page responder: page/location types, the packed bus
// address layout, the responder state encoding and the default burst length.
package mcDefs;
  localparam int unsigned LOC_BITS_DEF  = 12;
  localparam int unsigned BURST_LEN_DEF = 4;

  typedef logic [3:0]              page_t;
  typedef logic [LOC_BITS_DEF-1:0] loc_t;

  typedef struct packed {
    page_t page;
    loc_t  loc;
  } bus_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_TURN,
    RD_DATA,
    WR_DATA
  } resp_state_e;
endpackage

// File: rtl/mem_page_array.sv
// One page of word storage: synchronous write port, asynchronous read port on a shared address.
module mem_page_array #(
  parameter int unsigned LOC_BITS = 12,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                clk,
  input  logic                we,
  input  logic [LOC_BITS-1:0] addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [2**LOC_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_page_responder.sv
// Main-bus memory responder for one page: decodes {page,loc}, accepts write bursts and returns
// read bursts after a one-cycle turnaround. Optional ProtoErr output under MEM_PROTO_CHECK_EN.
module mem_page_responder
  import mcDefs::*;
#(
  parameter page_t       PAGE_ID   = 4'h2,
  parameter int unsigned LOC_BITS  = LOC_BITS_DEF,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              resetH,
  input  logic              AddrValid,
  input  logic              rw,
  input  logic [DATA_W-1:0] AddrData_in,
  output logic [DATA_W-1:0] AddrData_out,
  output logic              DataOE,
  output logic              DataValid,
  output logic              Busy
`ifdef MEM_PROTO_CHECK_EN
  ,
  output logic              ProtoErr
`endif
);
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  resp_state_e         state;
  logic [LOC_BITS-1:0] loc;
  logic [CNT_W-1:0]    cnt;
  logic [LOC_BITS-1:0] addr;
  logic [DATA_W-1:0]   rdata;
  logic                page_match;
  logic                hit;
  logic                last;
  logic                we;

  assign page_match = (page_t'(AddrData_in[DATA_W-1 -: 4]) == PAGE_ID);
  assign hit        = AddrValid && page_match;
  assign last       = (cnt == CNT_W'(BURST_LEN - 1));
  // Location arithmetic is LOC_BITS wide, so bursts wrap inside the page.
  assign addr       = loc + LOC_BITS'(cnt);
  assign we         = (state == WR_DATA);
  // Gating on the async-reset DataValid makes the output drop to zero on reset immediately.
  assign AddrData_out = DataValid ? rdata : '0;

  mem_page_array #(
    .LOC_BITS (LOC_BITS),
    .DATA_W   (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (AddrData_in),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state     <= IDLE;
      loc       <= '0;
      cnt       <= '0;
      DataOE    <= 1'b0;
      DataValid <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            loc   <= AddrData_in[LOC_BITS-1:0];
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= rw ? RD_TURN : WR_DATA;
          end
        end
        RD_TURN: begin
          state     <= RD_DATA;
          DataOE    <= 1'b1;
          DataValid <= 1'b1;
        end
        RD_DATA: begin
          if (last) begin
            state     <= IDLE;
            cnt       <= '0;
            DataOE    <= 1'b0;
            DataValid <= 1'b0;
            Busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_DATA: begin
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PROTO_CHECK_EN
  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      ProtoErr <= 1'b0;
    end else if (AddrValid && ((Busy && page_match) || $isunknown({rw, AddrData_in}))) begin
      ProtoErr <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_page_responder.sv
// Scoreboard bench for mem_page_responder: a word model of page 2 predicts every read burst.
module tb_mem_page_responder;
  logic        clk = 1'b0;
  logic        resetH;
  logic        AddrValid;
  logic        rw;
  logic [15:0] AddrData_in;
  logic [15:0] AddrData_out;
  logic        DataOE;
  logic        DataValid;
  logic        Busy;
`ifdef MEM_PROTO_CHECK_EN
  logic        ProtoErr;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] model [4096];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  mem_page_responder #(
    .PAGE_ID   (4'h2),
    .LOC_BITS  (12),
    .DATA_W    (16),
    .BURST_LEN (4)
  ) dut (
    .clk          (clk),
    .resetH       (resetH),
    .AddrValid    (AddrValid),
    .rw           (rw),
    .AddrData_in  (AddrData_in),
    .AddrData_out (AddrData_out),
    .DataOE       (DataOE),
    .DataValid    (DataValid),
    .Busy         (Busy)
`ifdef MEM_PROTO_CHECK_EN
    ,
    .ProtoErr     (ProtoErr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every valid read word is compared against the oldest prediction.
  always @(negedge clk) begin
    if (!resetH && DataValid) begin
      if (exp_q.size() == 0) check("unexpected_valid", {16'h0, AddrData_out}, 32'hDEAD_BEEF);
      else                   check("rd_data", {16'h0, AddrData_out}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic do_read(input logic [11:0] loc);
    @(posedge clk); #1;
    AddrValid = 1'b1; rw = 1'b1; AddrData_in = {4'h2, loc};
    for (int i = 0; i < 4; i++) exp_q.push_back(model[12'(loc + i)]);
    @(posedge clk); #1;
    AddrValid = 1'b0; rw = 1'b0; AddrData_in = 16'h2FFF;
    check("rd_turn_busy", Busy, 1);
    check("rd_turn_oe", DataOE, 0);
    check("rd_turn_valid", DataValid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rd_busy", Busy, 1);
      check("rd_oe", DataOE, 1);
      check("rd_valid", DataValid, 1);
    end
    @(posedge clk); #1;
    check("rd_end_busy", Busy, 0);
    check("rd_end_oe", DataOE, 0);
    check("rd_end_valid", DataValid, 0);
    check("rd_end_out", AddrData_out, 0);
  endtask

  // cut < 4 asserts reset in the cycle that would carry word[cut].
  task automatic do_write(input logic [3:0] pg, input logic [11:0] loc, input logic [63:0] words,
                          input bit glitch, input int cut);
    @(posedge clk); #1;
    AddrValid = 1'b1; rw = 1'b0; AddrData_in = {pg, loc};
    for (int i = 0; i < cut; i++) begin
      @(posedge clk); #1;
      AddrValid   = glitch && (i == 0);
      rw          = glitch && (i == 0);
      AddrData_in = words[16*i +: 16];
      check("wr_busy", Busy, (pg == 4'h2) ? 1 : 0);
      check("wr_oe", DataOE, 0);
      check("wr_valid", DataValid, 0);
      if (pg == 4'h2) model[12'(loc + i)] = words[16*i +: 16];
    end
    @(posedge clk); #1;
    AddrValid = 1'b0; rw = 1'b0;
    if (cut < 4) begin
      resetH = 1'b1;
      #1;
      check("wr_cut_busy", Busy, 0);
      @(posedge clk); #1;
      resetH = 1'b0;
    end else begin
      check("wr_end_busy", Busy, 0);
    end
  endtask

  initial begin
    resetH = 1'b1; AddrValid = 1'b0; rw = 1'b0; AddrData_in = '0;
    #2;
    check("rst_out", AddrData_out, 0);
    check("rst_oe", DataOE, 0);
    check("rst_valid", DataValid, 0);
    check("rst_busy", Busy, 0);
`ifdef MEM_PROTO_CHECK_EN
    check("rst_proto", ProtoErr, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    resetH = 1'b0;

    do_write(4'h2, 12'h010, 64'h4444_3333_2222_1111, 1'b0, 4);
    do_read(12'h010);

    // Foreign page: neither a read nor a write may disturb this page.
    @(posedge clk); #1;
    AddrValid = 1'b1; rw = 1'b1; AddrData_in = 16'h3010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      AddrValid = 1'b0;
      check("foreign_busy", Busy, 0);
      check("foreign_oe", DataOE, 0);
      check("foreign_valid", DataValid, 0);
    end
    do_write(4'h3, 12'h010, 64'h9999_8888_7777_6666, 1'b0, 4);
    do_read(12'h010);

    do_write(4'h2, 12'hFFE, 64'hD004_C003_B002_A001, 1'b0, 4);
    do_read(12'hFFE);
    do_read(12'h010);

    do_write(4'h2, 12'h020, 64'h2DDD_2CCC_2BBB_2AAA, 1'b1, 4);
`ifdef MEM_PROTO_CHECK_EN
    check("proto_set", ProtoErr, 1);
`endif
    do_read(12'h020);
`ifdef MEM_PROTO_CHECK_EN
    check("proto_sticky", ProtoErr, 1);
`endif

    do_write(4'h2, 12'h010, 64'h0000_0000_5BBB_5AAA, 1'b0, 2);
`ifdef MEM_PROTO_CHECK_EN
    check("proto_cleared", ProtoErr, 0);
`endif
    do_read(12'h010);

    // Reset at T+3 of a read: only the T+2 word is ever presented.
    @(posedge clk); #1;
    AddrValid = 1'b1; rw = 1'b1; AddrData_in = 16'h2010;
    exp_q.push_back(model[12'h010]);
    @(posedge clk); #1;
    AddrValid = 1'b0; rw = 1'b0;
    @(posedge clk); #1;
    check("rst_rd_valid_before", DataValid, 1);
    @(posedge clk); #1;
    resetH = 1'b1;
    #1;
    check("rst_rd_oe", DataOE, 0);
    check("rst_rd_valid", DataValid, 0);
    check("rst_rd_busy", Busy, 0);
    check("rst_rd_out", AddrData_out, 0);
    @(posedge clk); #1;
    resetH = 1'b0;
    do_read(12'h010);

    @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
